vote_session_ctrl: RTL and testbench

Session controller for the 11-voter majority vote datapath. It opens a timed voting window and accepts at most one ballot per voter (yes, no or abstain). It closes the window on timeout or when all voters have voted, then tallies and holds a registered majority decision. The latched ballot vector is exported so it can drive the combinational majority counter directly.

---
 rtl/vote_session_ctrl.sv | 165 ++++++++++++++++
 tb/tb_vote_session_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vote_session_ctrl.sv
// Voting session controller: opens a timed window, accepts one ballot per voter,
// closes on timeout or full turnout, then tallies and holds a registered majority decision.
module vote_session_ctrl #(
    parameter int N_VOTERS      = 11,
    parameter int WINDOW_CYCLES = 1000,
    parameter int TMR_W         = 10,
    parameter int CNT_W         = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [N_VOTERS-1:0] yes_btn,
    input  logic [N_VOTERS-1:0] no_btn,
    output logic                busy,
    output logic [N_VOTERS-1:0] voted_mask,
    output logic [N_VOTERS-1:0] votes_out,
    output logic [CNT_W-1:0]    yes_count,
    output logic [CNT_W-1:0]    no_count,
    output logic                decision,
    output logic                decision_valid
);

    typedef enum logic [1:0] {IDLE, OPEN, TALLY, DONE} state_t;

    localparam logic [CNT_W-1:0] MAJORITY   = CNT_W'((N_VOTERS + 1) / 2);
    localparam logic [TMR_W-1:0] TIMER_LOAD = TMR_W'(WINDOW_CYCLES - 1);

    state_t              state_reg, state_next;
    logic [TMR_W-1:0]    timer_reg, timer_next;
    logic [N_VOTERS-1:0] mask_reg, mask_next;
    logic [N_VOTERS-1:0] votes_reg, votes_next;
    logic [CNT_W-1:0]    yes_reg, yes_next;
    logic [CNT_W-1:0]    no_reg, no_next;
    logic                decision_reg, decision_next;
    logic                valid_reg, valid_next;
    logic                busy_reg, busy_next;
    logic [N_VOTERS-1:0] yes_acc, no_acc;

    // A ballot is accepted only from a voter who has not voted yet and whose
    // request is unambiguous (exactly one button pressed).
    generate
        for (genvar gi = 0; gi < N_VOTERS; gi++) begin : g_accept
            assign yes_acc[gi] = yes_btn[gi] & ~no_btn[gi] & ~mask_reg[gi];
            assign no_acc[gi]  = no_btn[gi] & ~yes_btn[gi] & ~mask_reg[gi];
        end
    endgenerate

    function automatic logic [CNT_W-1:0] popcount(input logic [N_VOTERS-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_VOTERS; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    always_comb begin
        state_next    = state_reg;
        timer_next    = timer_reg;
        mask_next     = mask_reg;
        votes_next    = votes_reg;
        yes_next      = yes_reg;
        no_next       = no_reg;
        decision_next = decision_reg;
        valid_next    = valid_reg;
        busy_next     = busy_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = OPEN;
                    timer_next = TIMER_LOAD;
                    mask_next  = '0;
                    votes_next = '0;
                    yes_next   = '0;
                    no_next    = '0;
                    busy_next  = 1'b1;
                end
            end
            OPEN: begin
                if (abort) begin
                    state_next = IDLE;
                    timer_next = '0;
                    mask_next  = '0;
                    votes_next = '0;
                    yes_next   = '0;
                    no_next    = '0;
                    busy_next  = 1'b0;
                end else begin
                    mask_next  = mask_reg | yes_acc | no_acc;
                    votes_next = votes_reg | yes_acc;
                    yes_next   = yes_reg + popcount(yes_acc);
                    no_next    = no_reg + popcount(no_acc);
                    if (timer_reg == '0 || &mask_reg) begin
                        state_next = TALLY;
                    end else begin
                        timer_next = timer_reg - 1'b1;
                    end
                end
            end
            TALLY: begin
                state_next    = DONE;
                decision_next = (yes_reg >= MAJORITY);
                valid_next    = 1'b1;
                busy_next     = 1'b0;
            end
            DONE: begin
                if (abort) begin
                    state_next    = IDLE;
                    timer_next    = '0;
                    mask_next     = '0;
                    votes_next    = '0;
                    yes_next      = '0;
                    no_next       = '0;
                    decision_next = 1'b0;
                    valid_next    = 1'b0;
                end else if (start) begin
                    state_next    = OPEN;
                    timer_next    = TIMER_LOAD;
                    mask_next     = '0;
                    votes_next    = '0;
                    yes_next      = '0;
                    no_next       = '0;
                    decision_next = 1'b0;
                    valid_next    = 1'b0;
                    busy_next     = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            timer_reg    <= '0;
            mask_reg     <= '0;
            votes_reg    <= '0;
            yes_reg      <= '0;
            no_reg       <= '0;
            decision_reg <= 1'b0;
            valid_reg    <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            timer_reg    <= timer_next;
            mask_reg     <= mask_next;
            votes_reg    <= votes_next;
            yes_reg      <= yes_next;
            no_reg       <= no_next;
            decision_reg <= decision_next;
            valid_reg    <= valid_next;
            busy_reg     <= busy_next;
        end
    end

    assign busy           = busy_reg;
    assign voted_mask     = mask_reg;
    assign votes_out      = votes_reg;
    assign yes_count      = yes_reg;
    assign no_count       = no_reg;
    assign decision       = decision_reg;
    assign decision_valid = valid_reg;

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Self-checking bench for vote_session_ctrl with a 16-cycle window and a result scoreboard.
module tb_vote_session_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [10:0] yes_btn;
    logic [10:0] no_btn;
    logic        busy;
    logic [10:0] voted_mask;
    logic [10:0] votes_out;
    logic [3:0]  yes_count;
    logic [3:0]  no_count;
    logic        decision;
    logic        decision_valid;

    typedef struct packed {
        logic [3:0]  y;
        logic [3:0]  n;
        logic [10:0] mask;
        logic [10:0] votes;
        logic        dec;
    } exp_t;

    exp_t sb_q[$];
    int   asserts  = 0;
    int   failures = 0;

    vote_session_ctrl #(
        .N_VOTERS(11),
        .WINDOW_CYCLES(16),
        .TMR_W(4),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .yes_btn(yes_btn),
        .no_btn(no_btn),
        .busy(busy),
        .voted_mask(voted_mask),
        .votes_out(votes_out),
        .yes_count(yes_count),
        .no_count(no_count),
        .decision(decision),
        .decision_valid(decision_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic open_session();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Wait (bounded) for a result, then pop the oldest expectation and compare.
    task automatic wait_result(input string tag);
        exp_t e;
        int   n = 0;
        while (!decision_valid && n < 60) begin
            tick();
            n++;
        end
        asserts++;
        if (decision_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s_timeout: decision_valid=%b required 1", tag, decision_valid);
        end
        asserts++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL %s_scoreboard: queue empty, required 1 entry", tag);
        end else begin
            e = sb_q.pop_front();
            if ({yes_count, no_count, voted_mask, votes_out, decision} !== e) begin
                failures++;
                $display("FAIL %s_result: yes=%0d no=%0d mask=%h votes=%h dec=%b required yes=%0d no=%0d mask=%h votes=%h dec=%b",
                         tag, yes_count, no_count, voted_mask, votes_out, decision,
                         e.y, e.n, e.mask, e.votes, e.dec);
            end
        end
        $display("%s: yes=%0d no=%0d mask=%h votes=%h decision=%b", tag,
                 yes_count, no_count, voted_mask, votes_out, decision);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; yes_btn = '0; no_btn = '0;
        tick(); tick();
        asserts++;
        if ({busy, voted_mask, votes_out, yes_count, no_count, decision, decision_valid} !== '0) begin
            failures++;
            $display("FAIL reset_state: outputs=%h required 0",
                     {busy, voted_mask, votes_out, yes_count, no_count, decision, decision_valid});
        end
        rst_n = 1'b1;
        tick();
        open_session();
        yes_btn = 11'h005;
        tick();
        yes_btn = '0;
        asserts++;
        if ({busy, voted_mask, yes_count} !== {1'b1, 11'h005, 4'd2}) begin
            failures++;
            $display("FAIL reset_pre_open: busy=%b mask=%h yes=%0d required 1 005 2", busy, voted_mask, yes_count);
        end
        #3 rst_n = 1'b0;
        #1;
        asserts++;
        if ({busy, voted_mask, votes_out, yes_count, no_count, decision, decision_valid} !== '0) begin
            failures++;
            $display("FAIL reset_async: outputs=%h required 0",
                     {busy, voted_mask, votes_out, yes_count, no_count, decision, decision_valid});
        end
        #2 rst_n = 1'b1;
        tick();
        asserts++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: busy=%b required 0", busy);
        end
        open_session();
        asserts++;
        if ({busy, voted_mask, yes_count} !== {1'b1, 11'h000, 4'd0}) begin
            failures++;
            $display("FAIL reset_reopen: busy=%b mask=%h yes=%0d required 1 000 0", busy, voted_mask, yes_count);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        $display("reset: async clear and fresh session done");
    endtask

    task automatic test_early_close();
        exp_t e;
        e = '{y: 4'd6, n: 4'd5, mask: 11'h7FF, votes: 11'h03F, dec: 1'b1};
        sb_q.push_back(e);
        open_session();
        yes_btn = 11'h007; tick();
        yes_btn = 11'h038; tick();
        yes_btn = '0; no_btn = 11'h0C0; tick();
        no_btn = 11'h700; tick();
        no_btn = '0;
        asserts++;
        if ({busy, decision_valid, voted_mask} !== {1'b1, 1'b0, 11'h7FF}) begin
            failures++;
            $display("FAIL early_full: busy=%b valid=%b mask=%h required 1 0 7ff", busy, decision_valid, voted_mask);
        end
        tick();
        asserts++;
        if ({busy, decision_valid} !== 2'b10) begin
            failures++;
            $display("FAIL early_tally: busy=%b valid=%b required 1 0", busy, decision_valid);
        end
        tick();
        asserts++;
        if ({busy, decision_valid} !== 2'b01) begin
            failures++;
            $display("FAIL early_latency: busy=%b valid=%b required 0 1", busy, decision_valid);
        end
        wait_result("early_close");
        tick(); tick(); tick();
        asserts++;
        if ({decision_valid, yes_count, no_count, voted_mask, votes_out, decision} !== {1'b1, e}) begin
            failures++;
            $display("FAIL early_hold: valid=%b yes=%0d no=%0d votes=%h dec=%b required 1 6 5 03f 1",
                     decision_valid, yes_count, no_count, votes_out, decision);
        end
    endtask

    task automatic test_back_to_back();
        open_session();
        asserts++;
        if ({decision_valid, decision, busy, yes_count, no_count, voted_mask} !== {1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 11'h000}) begin
            failures++;
            $display("FAIL b2b_start: valid=%b dec=%b busy=%b yes=%0d no=%0d mask=%h required 0 0 1 0 0 000",
                     decision_valid, decision, busy, yes_count, no_count, voted_mask);
        end
        sb_q.push_back('{y: 4'd5, n: 4'd6, mask: 11'h7FF, votes: 11'h01F, dec: 1'b0});
        yes_btn = 11'h01F; no_btn = 11'h7E0;
        tick();
        yes_btn = '0; no_btn = '0;
        wait_result("back_to_back");
    endtask

    task automatic test_timeout();
        int n = 0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        asserts++;
        if ({busy, voted_mask, votes_out, yes_count, no_count, decision, decision_valid} !== '0) begin
            failures++;
            $display("FAIL done_abort: outputs=%h required 0",
                     {busy, voted_mask, votes_out, yes_count, no_count, decision, decision_valid});
        end
        sb_q.push_back('{y: 4'd5, n: 4'd0, mask: 11'h01F, votes: 11'h01F, dec: 1'b0});
        open_session();
        yes_btn = 11'h01F;
        tick();
        n++;
        yes_btn = '0;
        while (!decision_valid && n < 60) begin
            tick();
            n++;
        end
        // 16 OPEN cycles plus one TALLY cycle
        asserts++;
        if (n !== 17) begin
            failures++;
            $display("FAIL timeout_len: edges_to_valid=%0d required 17", n);
        end
        wait_result("timeout");
    endtask

    task automatic test_ballot_rules();
        sb_q.push_back('{y: 4'd1, n: 4'd1, mask: 11'h088, votes: 11'h008, dec: 1'b0});
        open_session();
        yes_btn = 11'h008; no_btn = 11'h008;
        tick();
        asserts++;
        if (voted_mask !== 11'h000) begin
            failures++;
            $display("FAIL rules_both: mask=%h required 000", voted_mask);
        end
        no_btn = '0;
        tick();
        asserts++;
        if ({voted_mask, yes_count} !== {11'h008, 4'd1}) begin
            failures++;
            $display("FAIL rules_yes: mask=%h yes=%0d required 008 1", voted_mask, yes_count);
        end
        yes_btn = '0; no_btn = 11'h008;
        tick();
        no_btn = '0;
        asserts++;
        if ({no_count, votes_out} !== {4'd0, 11'h008}) begin
            failures++;
            $display("FAIL rules_final: no=%0d votes=%h required 0 008", no_count, votes_out);
        end
        for (int i = 0; i < 12; i++) tick();
        no_btn = 11'h080;
        tick();
        no_btn = '0;
        asserts++;
        if ({busy, decision_valid} !== 2'b10) begin
            failures++;
            $display("FAIL rules_last_cycle: busy=%b valid=%b required 1 0", busy, decision_valid);
        end
        wait_result("ballot_rules");
    endtask

    task automatic test_abort();
        open_session();
        yes_btn = 11'h003; tick();
        yes_btn = '0; no_btn = 11'h004; tick();
        no_btn = '0; start = 1'b1; tick();
        start = 1'b0;
        asserts++;
        if ({busy, voted_mask, yes_count, no_count} !== {1'b1, 11'h007, 4'd2, 4'd1}) begin
            failures++;
            $display("FAIL abort_start_ignored: busy=%b mask=%h yes=%0d no=%0d required 1 007 2 1",
                     busy, voted_mask, yes_count, no_count);
        end
        abort = 1'b1; yes_btn = 11'h100;
        tick();
        abort = 1'b0; yes_btn = '0;
        asserts++;
        if ({busy, voted_mask, votes_out, yes_count, no_count, decision_valid} !== '0) begin
            failures++;
            $display("FAIL abort_clear: busy=%b mask=%h votes=%h yes=%0d no=%0d valid=%b required all 0",
                     busy, voted_mask, votes_out, yes_count, no_count, decision_valid);
        end
        abort = 1'b1; tick(); abort = 1'b0;
        tick(); tick();
        asserts++;
        if ({busy, decision_valid} !== 2'b00) begin
            failures++;
            $display("FAIL abort_idle: busy=%b valid=%b required 0 0", busy, decision_valid);
        end
        $display("abort: session cancelled, mask=%h yes=%0d no=%0d", voted_mask, yes_count, no_count);
    endtask

    initial begin
        test_reset();
        test_early_close();
        test_back_to_back();
        test_timeout();
        test_ballot_rules();
        test_abort();
        asserts++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: entries=%0d required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
